// File: rtl/spi_flash_pkg.sv
// spi_flash_pkg: opcodes, FSM state encoding and default IDs shared by the flash responder and the flash sequencer.
//   No ports; import with "import spi_flash_pkg::*;".
package spi_flash_pkg;

   localparam logic [7:0] CMD_WRITE_ENABLE = 8'h06;
   localparam logic [7:0] CMD_DEVICE_ID    = 8'h90;
   localparam logic [7:0] CMD_READ_DATA    = 8'h03;
   localparam logic [7:0] CMD_PAGE_PROGRAM = 8'h02;
   localparam logic [7:0] CMD_SECTOR_ERASE = 8'h20;

   localparam logic [7:0] DEF_MFR_ID = 8'hEF;
   localparam logic [7:0] DEF_DEV_ID = 8'h16;

   typedef enum logic [3:0] {
      ST_INIT,
      ST_IDLE,
      ST_CMD,
      ST_ADDR,
      ST_READ,
      ST_PROG,
      ST_WAIT_CS,
      ST_IGNORE,
      ST_ERASE
   } state_e;

endpackage

// File: rtl/spi_slave_sync.sv
// spi_slave_sync: brings sclk/cs_n/mosi into the clk domain, detects edges and assembles MSB-first bytes.
//   clk, rst_n        : system clock, async active-low reset
//   sclk, cs_n, mosi  : raw SPI pins
//   rx_byte           : byte being assembled, complete when byte_valid is high
//   byte_valid        : one-clk pulse on the 8th sclk rise of a byte
//   sclk_fall         : one-clk pulse per synchronised sclk fall
//   cs_fall, cs_rise  : one-clk pulses on synchronised chip-select edges
//   cs_high           : synchronised chip-select level (deselected)
module spi_slave_sync (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sclk,
   input  logic       cs_n,
   input  logic       mosi,
   output logic [7:0] rx_byte,
   output logic       byte_valid,
   output logic       sclk_fall,
   output logic       cs_fall,
   output logic       cs_rise,
   output logic       cs_high
);

   logic [2:0] sclk_sync_q, sclk_sync_d;
   logic [2:0] cs_sync_q, cs_sync_d;
   logic [1:0] mosi_sync_q, mosi_sync_d;
   logic [6:0] rx_q, rx_d;
   logic [2:0] bit_q, bit_d;
   logic       sclk_rise, shift_en;

   // Shifting is qualified by the delayed cs stage so a final rise that lands
   // together with the cs rise still completes its byte.
   always_comb begin
      sclk_sync_d = {sclk_sync_q[1:0], sclk};
      cs_sync_d   = {cs_sync_q[1:0], cs_n};
      mosi_sync_d = {mosi_sync_q[0], mosi};
      sclk_rise   = sclk_sync_q[1] & ~sclk_sync_q[2];
      sclk_fall   = ~sclk_sync_q[1] & sclk_sync_q[2];
      cs_fall     = ~cs_sync_q[1] & cs_sync_q[2];
      cs_rise     = cs_sync_q[1] & ~cs_sync_q[2];
      cs_high     = cs_sync_q[1];
      shift_en    = sclk_rise & ~cs_sync_q[2];
      rx_byte     = {rx_q, mosi_sync_q[1]};
      byte_valid  = shift_en & (bit_q == 3'd7);
      rx_d        = shift_en ? rx_byte[6:0] : rx_q;
      bit_d       = cs_sync_q[2] ? 3'd0 : bit_q + {2'b00, shift_en};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_sync_q <= 3'b000;
         cs_sync_q   <= 3'b111;
         mosi_sync_q <= 2'b00;
         rx_q        <= 7'd0;
         bit_q       <= 3'd0;
      end else begin
         sclk_sync_q <= sclk_sync_d;
         cs_sync_q   <= cs_sync_d;
         mosi_sync_q <= mosi_sync_d;
         rx_q        <= rx_d;
         bit_q       <= bit_d;
      end
   end

endmodule

// File: rtl/spi_flash_responder.sv
// spi_flash_responder: SPI mode-0 slave emulating a small serial NOR flash held in an internal byte array.
//   clk, rst_n        : system clock, async active-low reset
//   sclk, cs_n, mosi  : SPI inputs from the master (asynchronous)
//   miso              : SPI data to the master
//   wel               : write-enable latch
//   busy              : high while the init fill or a sector erase runs
module spi_flash_responder
   import spi_flash_pkg::*;
#(
   parameter int         ADDR_W   = 8,
   parameter int         SECTOR_W = 4,
   parameter logic [7:0] MFR_ID   = DEF_MFR_ID,
   parameter logic [7:0] DEV_ID   = DEF_DEV_ID
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sclk,
   input  logic cs_n,
   input  logic mosi,
   output logic miso,
   output logic wel,
   output logic busy
);

   state_e              state_q, state_d;
   logic [23:0]         addr_q, addr_d, addr_n;
   logic [7:0]          cmd_q, cmd_d;
   logic [1:0]          bcnt_q, bcnt_d;
   logic [7:0]          tx_q, tx_d;
   logic                miso_q, miso_d;
   logic                wel_q, wel_d;
   logic                id_sel_q, id_sel_d;
   logic [ADDR_W-1:0]   cnt_q, cnt_d;
   logic [7:0]          mem_q [2**ADDR_W];
   logic                mem_we;
   logic [ADDR_W-1:0]   mem_addr;
   logic [7:0]          mem_wdata, mem_rdata;
   logic [7:0]          rx_byte;
   logic                byte_valid, sclk_fall, cs_fall, cs_rise, cs_high;
   logic                last_addr;

   spi_slave_sync u_sync (
      .clk        (clk),
      .rst_n      (rst_n),
      .sclk       (sclk),
      .cs_n       (cs_n),
      .mosi       (mosi),
      .rx_byte    (rx_byte),
      .byte_valid (byte_valid),
      .sclk_fall  (sclk_fall),
      .cs_fall    (cs_fall),
      .cs_rise    (cs_rise),
      .cs_high    (cs_high)
   );

   assign addr_n    = {addr_q[15:0], rx_byte};
   assign last_addr = (state_q == ST_ADDR) & byte_valid & (bcnt_q == 2'd2);
   assign mem_rdata = mem_q[mem_addr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_INIT;
      else        state_q <= state_d;
   end

   // The completed byte is decoded first; a coincident cs rise then acts on
   // the resulting state.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_INIT:  if (cnt_q == '1) state_d = ST_IDLE;
         ST_ERASE: if (cnt_q[SECTOR_W-1:0] == '1) state_d = ST_IDLE;
         ST_IDLE:  if (cs_fall) state_d = ST_CMD;
         ST_CMD:
            if (byte_valid)
               state_d = (rx_byte == CMD_READ_DATA || rx_byte == CMD_DEVICE_ID ||
                          rx_byte == CMD_PAGE_PROGRAM || rx_byte == CMD_SECTOR_ERASE)
                         ? ST_ADDR : ST_IGNORE;
         ST_ADDR:
            if (last_addr)
               state_d = (cmd_q == CMD_PAGE_PROGRAM) ? ST_PROG :
                         (cmd_q == CMD_SECTOR_ERASE) ? ST_WAIT_CS : ST_READ;
         default: ;
      endcase
      if (cs_rise && state_q != ST_INIT && state_q != ST_ERASE)
         state_d = (state_d == ST_WAIT_CS && wel_q) ? ST_ERASE : ST_IDLE;
   end

   always_comb begin
      addr_d    = addr_q;
      cmd_d     = cmd_q;
      bcnt_d    = bcnt_q;
      tx_d      = tx_q;
      miso_d    = miso_q;
      wel_d     = wel_q;
      id_sel_d  = id_sel_q;
      cnt_d     = '0;
      mem_we    = 1'b0;
      mem_addr  = addr_q[ADDR_W-1:0];
      mem_wdata = 8'hFF;
      if (sclk_fall) begin
         miso_d = (state_q == ST_READ) & tx_q[7];
         tx_d   = {tx_q[6:0], 1'b0};
      end
      case (state_q)
         ST_INIT: begin
            mem_we   = 1'b1;
            mem_addr = cnt_q;
            cnt_d    = cnt_q + 1'b1;
         end
         ST_ERASE: begin
            mem_we   = 1'b1;
            mem_addr = {addr_q[ADDR_W-1:SECTOR_W], cnt_q[SECTOR_W-1:0]};
            cnt_d    = cnt_q + 1'b1;
         end
         ST_CMD:
            if (byte_valid) begin
               cmd_d  = rx_byte;
               bcnt_d = 2'd0;
               if (rx_byte == CMD_WRITE_ENABLE) wel_d = 1'b1;
            end
         ST_ADDR:
            if (byte_valid) begin
               addr_d = addr_n;
               bcnt_d = bcnt_q + 1'b1;
               if (bcnt_q == 2'd2) begin
                  mem_addr = addr_n[ADDR_W-1:0];
                  id_sel_d = addr_n[0];
                  tx_d     = (cmd_q == CMD_DEVICE_ID) ? (addr_n[0] ? DEV_ID : MFR_ID) : mem_rdata;
               end
            end
         ST_READ:
            if (byte_valid) begin
               addr_d   = addr_q + 24'd1;
               mem_addr = addr_d[ADDR_W-1:0];
               id_sel_d = ~id_sel_q;
               tx_d     = (cmd_q == CMD_DEVICE_ID) ? (id_sel_q ? MFR_ID : DEV_ID) : mem_rdata;
            end
         ST_PROG:
            if (byte_valid) begin
               mem_we    = wel_q;
               mem_wdata = mem_rdata & rx_byte;
               addr_d    = addr_q + 24'd1;
            end
         default: ;
      endcase
      // Program/erase consume the latch once the full address was received.
      if (cs_rise && (state_q == ST_PROG || state_q == ST_WAIT_CS || last_addr) &&
          (cmd_q == CMD_PAGE_PROGRAM || cmd_q == CMD_SECTOR_ERASE))
         wel_d = 1'b0;
      if (cs_high) miso_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q   <= 24'd0;
         cmd_q    <= 8'd0;
         bcnt_q   <= 2'd0;
         tx_q     <= 8'd0;
         miso_q   <= 1'b0;
         wel_q    <= 1'b0;
         id_sel_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         addr_q   <= addr_d;
         cmd_q    <= cmd_d;
         bcnt_q   <= bcnt_d;
         tx_q     <= tx_d;
         miso_q   <= miso_d;
         wel_q    <= wel_d;
         id_sel_q <= id_sel_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) mem_q[mem_addr] <= mem_wdata;
   end

   always_comb begin
      miso = miso_q;
      wel  = wel_q;
      busy = (state_q == ST_INIT) | (state_q == ST_ERASE);
   end

endmodule

// File: tb/tb_spi_flash_responder.sv
// tb_spi_flash_responder: scoreboard bench driving SPI transactions into spi_flash_responder.
module tb_spi_flash_responder;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic sclk = 1'b0;
   logic cs_n = 1'b1;
   logic mosi = 1'b0;
   logic miso, wel, busy;

   int checks = 0;
   int errors = 0;
   string tag = "none";
   logic [7:0] snd_q[$];
   logic [7:0] exp_q[$];

   spi_flash_responder dut (
      .clk   (clk),
      .rst_n (rst_n),
      .sclk  (sclk),
      .cs_n  (cs_n),
      .mosi  (mosi),
      .miso  (miso),
      .wel   (wel),
      .busy  (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

   task automatic check(input string t, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", t, got, want);
      end
   endtask

   task automatic add(input logic [7:0] tx, input logic [7:0] ex);
      snd_q.push_back(tx);
      exp_q.push_back(ex);
   endtask

   task automatic hdr(input logic [7:0] c, input logic [23:0] a);
      add(c, 8'h00);
      add(a[23:16], 8'h00);
      add(a[15:8], 8'h00);
      add(a[7:0], 8'h00);
   endtask

   task automatic go(input int tail_bits, input bit settle);
      logic [7:0] t, r, e;
      int n;
      cs_n = 1'b0;
      #80;
      n = 0;
      while (snd_q.size() > 0) begin
         t = snd_q.pop_front();
         for (int i = 7; i >= 0; i--) begin
            mosi = t[i];
            #40;
            r[i] = miso;
            sclk = 1'b1;
            #40;
            sclk = 1'b0;
         end
         e = exp_q.pop_front();
         check($sformatf("%s_b%0d", tag, n), {24'd0, r}, {24'd0, e});
         n++;
      end
      for (int i = 0; i < tail_bits; i++) begin
         mosi = 1'b1;
         #40;
         sclk = 1'b1;
         #40;
         sclk = 1'b0;
      end
      #40;
      cs_n = 1'b1;
      mosi = 1'b0;
      if (settle) #200;
   endtask

   task automatic wren();
      tag = "wren";
      add(8'h06, 8'h00);
      go(0, 1);
      check("wel_set", {31'd0, wel}, 32'd1);
   endtask

   task automatic erase_len(input string t);
      int n;
      n = 0;
      while (!busy && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      check({t, "_start"}, {31'd0, busy}, 32'd1);
      n = 0;
      while (busy && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      check({t, "_len"}, n, 32'd16);
   endtask

   initial begin
      int n;
      #23;
      check("rst_busy", {31'd0, busy}, 32'd1);
      check("rst_wel", {31'd0, wel}, 32'd0);
      check("rst_miso", {31'd0, miso}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      n = 0;
      while (busy && n < 1000) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("init_len", n, 32'd256);
      #100;

      tag = "rd10";
      hdr(8'h03, 24'h000010);
      repeat (4) add(8'h00, 8'hFF);
      go(0, 1);

      tag = "id0";
      hdr(8'h90, 24'h000000);
      add(8'h00, 8'hEF);
      add(8'h00, 8'h16);
      go(0, 1);
      tag = "id1";
      hdr(8'h90, 24'h000001);
      add(8'h00, 8'h16);
      add(8'h00, 8'hEF);
      add(8'h00, 8'h16);
      go(0, 1);
      check("wel_after_id", {31'd0, wel}, 32'd0);

      wren();
      tag = "pgfe";
      hdr(8'h02, 24'h0000FE);
      add(8'h12, 8'h00);
      add(8'h34, 8'h00);
      add(8'h56, 8'h00);
      go(0, 1);
      check("wel_after_pg", {31'd0, wel}, 32'd0);
      tag = "rdfe";
      hdr(8'h03, 24'h0000FE);
      add(8'h00, 8'h12);
      add(8'h00, 8'h34);
      add(8'h00, 8'h56);
      add(8'h00, 8'hFF);
      go(0, 1);

      tag = "pg_nowel";
      hdr(8'h02, 24'h000020);
      add(8'h00, 8'h00);
      go(0, 1);
      tag = "rd20a";
      hdr(8'h03, 24'h000020);
      add(8'h00, 8'hFF);
      go(0, 1);
      wren();
      tag = "pgf0";
      hdr(8'h02, 24'h000020);
      add(8'hF0, 8'h00);
      go(0, 1);
      wren();
      tag = "pg3c";
      hdr(8'h02, 24'h000020);
      add(8'h3C, 8'h00);
      go(0, 1);
      tag = "rd20b";
      hdr(8'h03, 24'h000020);
      add(8'h00, 8'h30);
      go(0, 1);

      wren();
      tag = "pg13";
      hdr(8'h02, 24'h000013);
      add(8'h00, 8'h00);
      go(0, 1);
      wren();
      tag = "pg23";
      hdr(8'h02, 24'h000023);
      add(8'h00, 8'h00);
      go(0, 1);
      wren();
      tag = "er15";
      hdr(8'h20, 24'h000015);
      go(0, 0);
      erase_len("erase1");
      #200;
      check("wel_after_erase", {31'd0, wel}, 32'd0);
      tag = "rd_sect";
      hdr(8'h03, 24'h000010);
      repeat (16) add(8'h00, 8'hFF);
      go(0, 1);
      tag = "rd23";
      hdr(8'h03, 24'h000023);
      add(8'h00, 8'h00);
      go(0, 1);

      wren();
      tag = "abort";
      add(8'h02, 8'h00);
      add(8'h00, 8'h00);
      add(8'h00, 8'h00);
      go(5, 1);
      check("wel_after_abort", {31'd0, wel}, 32'd1);
      tag = "unk";
      add(8'hAB, 8'h00);
      add(8'h55, 8'h00);
      add(8'h00, 8'h00);
      add(8'hFF, 8'h00);
      go(0, 1);
      check("wel_after_unk", {31'd0, wel}, 32'd1);
      tag = "rd20c";
      hdr(8'h03, 24'h000020);
      add(8'h00, 8'h30);
      add(8'h00, 8'hFF);
      add(8'h00, 8'hFF);
      add(8'h00, 8'h00);
      go(0, 1);
      check("miso_idle", {31'd0, miso}, 32'd0);

      tag = "er20";
      hdr(8'h20, 24'h000020);
      go(0, 0);
      #80;
      check("busy_mid", {31'd0, busy}, 32'd1);
      tag = "wren_busy";
      add(8'h06, 8'h00);
      go(0, 1);
      check("wel_busy_ignored", {31'd0, wel}, 32'd0);
      check("busy_done", {31'd0, busy}, 32'd0);
      tag = "rd20d";
      hdr(8'h03, 24'h000020);
      repeat (4) add(8'h00, 8'hFF);
      go(0, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
